// File: rtl/vid_pkg.sv
// Shared definitions for the video timing to AXI4-Stream path: beat layout,
// FSM state encoding and default counter width.
package vid_pkg;

  localparam int CNT_W_DEF = 12;

  // A FIFO beat is {tuser, tlast, tdata}; the control bits sit above the pixel.
  localparam int BEAT_CTRL_W = 2;
  localparam int BEAT_LAST_OFS = 0;
  localparam int BEAT_USER_OFS = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } vid_state_t;

endpackage

// File: rtl/vid_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is held in an
// output register loaded from the storage array one cycle after it is written.
module vid_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             vid_clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic [CW-1:0]    w_used;
  logic             w_wr_en;
  logic             w_load;

  // Occupancy includes the entry already moved into the output register.
  assign w_used  = r_count + CW'(r_valid);
  assign o_full  = (w_used == CW'(DEPTH));
  assign o_empty = !r_valid;
  assign o_data  = r_data;

  // A pop frees a slot in the same cycle, so push-on-full-with-pop is accepted.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_load  = (!r_valid || i_pop) && (r_count != '0);

  always_ff @(posedge vid_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_valid  <= 1'b1;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end
      case ({w_wr_en, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vid_timing2axis.sv
// Parallel video timing (vsync/de/data) to AXI4-Stream video with SOF/EOL
// marking, frame geometry measurement and a stall-absorbing output FIFO.
module vid_timing2axis
  import vid_pkg::*;
#(
  parameter int   DATA_W     = 24,
  parameter int   FIFO_DEPTH = 16,
  parameter int   CNT_W      = CNT_W_DEF,
  parameter logic VSYNC_POL  = 1'b1
) (
  input  logic              vid_clk,
  input  logic              rst,
  input  logic              vid_vsync,
  input  logic              vid_de,
  input  logic [DATA_W-1:0] vid_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height,
  output logic              size_valid,
  output logic              overflow
);

  localparam int BEAT_W = DATA_W + BEAT_CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  vid_state_t        r_state;
  vid_state_t        w_state_next;
  logic              r_vs_prev;
  logic              r_hold_v;
  logic              r_hold_user;
  logic [DATA_W-1:0] r_hold_data;
  logic [CNT_W-1:0]  r_x_cnt;
  logic [CNT_W-1:0]  r_y_cnt;
  logic [CNT_W-1:0]  r_last_w;
  logic [CNT_W-1:0]  r_frame_w;
  logic [CNT_W-1:0]  r_frame_h;
  logic              r_size_valid;
  logic              r_overflow;

  logic              w_vs_act;
  logic              w_frame_ev;
  logic              w_cap;
  logic              w_sof;
  logic              w_push;
  logic              w_push_last;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_line_len;
  logic [CNT_W-1:0]  w_y_inc;
  logic [CNT_W-1:0]  w_y_eff;
  logic [BEAT_W-1:0] w_push_beat;
  logic [BEAT_W-1:0] w_pop_beat;

  assign w_vs_act   = (vid_vsync == VSYNC_POL);
  assign w_frame_ev = w_vs_act && !r_vs_prev;

  // A pixel coinciding with a frame event already belongs to the new frame.
  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_sof        = 1'b0;
    if (w_frame_ev || (r_state != ST_IDLE)) begin
      w_sof = w_frame_ev || (r_state == ST_ARMED);
      w_cap = vid_de;
      if (vid_de) begin
        w_state_next = ST_ACTIVE;
      end else if (w_frame_ev) begin
        w_state_next = ST_ARMED;
      end
    end
  end

  // The held pixel always leaves next cycle; only its tlast depends on what follows.
  assign w_push      = r_hold_v;
  assign w_push_last = r_hold_v && (!vid_de || w_frame_ev);
  assign w_push_beat = {r_hold_user, w_push_last, r_hold_data};

  assign w_line_len = (r_x_cnt == CNT_MAX) ? CNT_MAX : (r_x_cnt + CNT_ONE);
  assign w_y_inc    = (r_y_cnt == CNT_MAX) ? CNT_MAX : (r_y_cnt + CNT_ONE);
  assign w_y_eff    = w_push_last ? w_y_inc : r_y_cnt;

  assign w_pop = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      // Treat vsync as already active so a sync held through reset is not an edge.
      r_vs_prev    <= 1'b1;
      r_hold_v     <= 1'b0;
      r_hold_user  <= 1'b0;
      r_hold_data  <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_last_w     <= '0;
      r_frame_w    <= '0;
      r_frame_h    <= '0;
      r_size_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_vs_prev <= w_vs_act;
      r_hold_v  <= w_cap;
      if (w_cap) begin
        r_hold_data <= vid_data;
        r_hold_user <= w_sof;
      end

      if (w_push) begin
        if (w_push_last) begin
          r_x_cnt  <= '0;
          r_last_w <= w_line_len;
        end else begin
          r_x_cnt <= w_line_len;
        end
      end

      r_size_valid <= 1'b0;
      if (w_frame_ev && (w_y_eff != '0)) begin
        r_frame_w    <= w_push_last ? w_line_len : r_last_w;
        r_frame_h    <= w_y_eff;
        r_size_valid <= 1'b1;
        r_y_cnt      <= '0;
      end else begin
        r_y_cnt <= w_y_eff;
      end

      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  vid_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .vid_clk (vid_clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_pop_beat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_axis_tvalid = !w_fifo_empty;
  assign m_axis_tdata  = w_pop_beat[DATA_W-1:0];
  assign m_axis_tlast  = w_pop_beat[DATA_W + BEAT_LAST_OFS];
  assign m_axis_tuser  = w_pop_beat[DATA_W + BEAT_USER_OFS];

  assign frame_width  = r_frame_w;
  assign frame_height = r_frame_h;
  assign size_valid   = r_size_valid;
  assign overflow     = r_overflow;

endmodule

// File: doc/vid_timing2axis.md
# vid_timing2axis

Converts raw parallel video timing (vsync/hsync/de + 24-bit RGB) into an AXI4-Stream video stream: tuser marks start of frame, tlast marks end of line. It sits directly upstream of the video-to-DRAM capture writer, which consumes tuser/tlast/tvalid/tdata. A small output FIFO absorbs downstream stalls. The block also measures frame geometry and reports it to software.

## Interface
Parameters:
- DATA_W, 24, pixel width (RGB, passed through unchanged)
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4
- CNT_W, 12, width of x/y counters and size outputs
- VSYNC_POL, 1, active level of vid_vsync (1 = active-high)

Ports:
- vid_clk  in  1  pixel clock; the only clock
- rst  in  1  reset, synchronous, active-high; clock vid_clk
- vid_vsync  in  1  vertical sync, polarity per VSYNC_POL
- vid_de  in  1  data enable, 1 = active pixel
- vid_data  in  DATA_W  pixel, valid when vid_de=1
- m_axis_tdata  out  DATA_W  pixel
- m_axis_tvalid  out  1  beat valid
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- m_axis_tready  in  1  downstream ready
- frame_width  out  CNT_W  pixels in the last line of the previous frame
- frame_height  out  CNT_W  lines in the previous frame
- size_valid  out  1  one-cycle pulse when frame_width/height update
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

## Operation
- vs_act = vid_vsync XNOR VSYNC_POL. Frame event = rising edge of vs_act (vs_act=1, previous sample 0).
- FSM states:
  - IDLE: entered from reset; all pixels are discarded. Frame event -> ARMED.
  - ARMED: sof_pending=1. First vid_de=1 -> ACTIVE.
  - ACTIVE: a frame event returns to ARMED.
- Hold register (hold_v, hold_data, hold_user) gives one-pixel lookahead for tlast. A pixel with vid_de=1 in ARMED/ACTIVE is captured into hold, with hold_user=sof_pending, and clears sof_pending.
- Push hold to the FIFO with tlast=0 when hold_v=1 and a new pixel arrives in the same cycle. Push with tlast=1 when hold_v=1 and either vid_de=0 or a frame event occurs.
- Frame event during vid_de=1 (mid-line): the held pixel is pushed with tlast=1. The current-cycle pixel is captured as a new hold entry with hold_user=1.
- FIFO full at push time: the entry is dropped and overflow is set. overflow clears only on rst. The stream is not repaired.
- Counters:
  - x_cnt counts pixels per line and resets on the tlast push.
  - y_cnt counts tlast pushes per frame.
  - Both saturate at 2^CNT_W-1.
- On a frame event with y_cnt>0 (including the line closed by that event): latch frame_width = last line's pixel count and frame_height = y_cnt, pulse size_valid, clear y_cnt.
- FIFO pop happens when m_axis_tvalid && m_axis_tready.

## Timing
- Reset values: m_axis_tvalid=0, tdata/tuser/tlast=0, frame_width=0, frame_height=0, size_valid=0, overflow=0. FIFO is flushed, hold_v=0, state=IDLE.
- Reset mid-frame discards everything, including a partial line. Output resumes only after the next frame event.
- Latency with the FIFO empty and tready=1:
  - pixel k is sampled at edge N;
  - it is pushed at edge N+1 (next pixel present, or de fell);
  - m_axis_tvalid and tdata for pixel k are visible after edge N+2.
- FIFO is first-word-fall-through with registered outputs. Push and pop in the same cycle on a full FIFO is allowed and is not an overflow.
- size_valid rises the cycle after the frame-event edge and lasts 1 cycle.
- tvalid never drops without a handshake. tdata, tuser and tlast stay stable while tvalid=1 and tready=0.

## Structure
- Shared video package holds the AXIS beat field layout ({tuser, tlast, tdata}), the FSM state encoding and the CNT_W default.
- One sub-module, vid_sync_fifo: a synchronous FWFT FIFO, width DATA_W+2, depth FIFO_DEPTH, with full/empty outputs.
- The top level contains the FSM, hold register, counters and size latch.

## Test plan
- 4x3 frame, tready=1: 12 beats. tuser on beat 0 only; tlast on beats 3, 7 and 11. At the next frame event, frame_width=4, frame_height=3 and size_valid pulses once.
- Pixels and lines before the first frame event after rst produce no beats. The first beat after the event carries tuser=1.
- 1-pixel lines (vid_de high for 1 cycle): every beat has tlast=1, and the first beat has both tuser=1 and tlast=1.
- Frame event mid-line of an 8-pixel line after pixel 5: beat 4 has tlast=1, pixel 5 carries tuser=1, frame_width=5.
- FIFO_DEPTH=4, tready=0 across a 10-pixel line:
  - overflow=1 and stays set;
  - after tready=1, exactly the first 4 pushed beats emerge, in order;
  - tdata stays stable throughout the stall.
- rst asserted mid-line: tvalid=0 next cycle and all outputs at reset values. No beat appears until a new frame event.
